// File: rtl/aes128_round_engine.sv
// aes128_round_engine: iterative AES-128 encryptor, 2 cycles/round, optional AES_ZEROIZE_EN wipe of key/state/output after handoff
package aes128_pkg;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as x^254, followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
    x2 = gmul(x, x);
    x3 = gmul(x2, x);
    x6 = gmul(x3, x3);
    x12 = gmul(x6, x6);
    x15 = gmul(x12, x3);
    x30 = gmul(x15, x15);
    x60 = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    v = gmul(x252, x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
endpackage

// table_lookup: registered T0..T3 lookups of the four bytes of one state column
module table_lookup import aes128_pkg::*; (
  input  logic        clk,
  input  logic        en,
  input  logic [31:0] word,
  output logic [31:0] t0,
  output logic [31:0] t1,
  output logic [31:0] t2,
  output logic [31:0] t3
);
  logic [7:0] s0, s1, s2, s3;
  assign s0 = sbox(word[31:24]);
  assign s1 = sbox(word[23:16]);
  assign s2 = sbox(word[15:8]);
  assign s3 = sbox(word[7:0]);
  // Each table holds the S-box byte already scaled by its MixColumns coefficients.
  always_ff @(posedge clk)
    if (en) begin
      t0 <= {xt(s0), s0, s0, xt(s0) ^ s0};
      t1 <= {xt(s1) ^ s1, xt(s1), s1, s1};
      t2 <= {s2, xt(s2) ^ s2, xt(s2), s2};
      t3 <= {s3, s3, xt(s3) ^ s3, xt(s3)};
    end
endmodule

// s4: registered SubWord for key expansion
module s4 import aes128_pkg::*; (
  input  logic        clk,
  input  logic        en,
  input  logic [31:0] word,
  output logic [31:0] sub
);
  // Four parallel S-box lookups, captured one cycle later.
  always_ff @(posedge clk)
    if (en) sub <= {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
endmodule

// aes128_round_engine: top-level round sequencer
module aes128_round_engine import aes128_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, LOOKUP, COMBINE, DONE} fsm_t;
  fsm_t st, nxt;
  logic [127:0] state_reg, key_reg, mix_blk, fin_blk, nk;
  logic [3:0] round;
  logic [7:0] rcon;
  logic [31:0] p0 [4], p1 [4], p2 [4], p3 [4], mix [4], fin [4];
  logic [31:0] sub, n0;
  logic last;
  assign last = round == 4'd10;
  assign in_ready = st == IDLE;
  assign busy = st != IDLE;
  assign out_valid = st == DONE;
  assign n0 = key_reg[127:96] ^ sub ^ {rcon, 24'h0};
  assign nk = {n0, n0 ^ key_reg[95:64], n0 ^ key_reg[95:64] ^ key_reg[63:32], n0 ^ key_reg[95:64] ^ key_reg[63:32] ^ key_reg[31:0]};
  s4 u_s4 (.clk(clk), .en(1'b1), .word({key_reg[23:0], key_reg[31:24]}), .sub(sub));
  genvar g;
  for (g = 0; g < 4; g++) begin : g_col
    table_lookup u_tl (
      .clk(clk), .en(1'b1), .word(state_reg[127-32*g -: 32]),
      .t0(p0[g]), .t1(p1[g]), .t2(p2[g]), .t3(p3[g])
    );
    assign mix[g] = p0[g] ^ p1[(g+1)%4] ^ p2[(g+2)%4] ^ p3[(g+3)%4] ^ nk[127-32*g -: 32];
    assign fin[g] = {p0[g][23:16], p1[(g+1)%4][15:8], p2[(g+2)%4][7:0], p3[(g+3)%4][31:24]} ^ nk[127-32*g -: 32];
  end
  assign mix_blk = {mix[0], mix[1], mix[2], mix[3]};
  assign fin_blk = {fin[0], fin[1], fin[2], fin[3]};
  // FSM state register.
  always_ff @(posedge clk)
    st <= rst ? IDLE : nxt;
  // Each round is a LOOKUP cycle followed by a COMBINE cycle; round 10 exits to DONE.
  always_comb
    nxt = st == IDLE ? (in_valid ? LOOKUP : IDLE) :
          st == LOOKUP ? COMBINE :
          st == COMBINE ? (last ? DONE : LOOKUP) :
          (out_ready ? IDLE : DONE);
  // Datapath: load on accept, advance state and key schedule on each COMBINE.
  always_ff @(posedge clk)
    if (rst) begin
      out_state <= '0;
      round <= '0;
      rcon <= 8'h01;
`ifdef AES_ZEROIZE_EN
      state_reg <= '0;
      key_reg <= '0;
`endif
    end else if (st == IDLE && in_valid) begin
      state_reg <= in_state ^ in_key;
      key_reg <= in_key;
      round <= 4'd1;
      rcon <= 8'h01;
    end else if (st == COMBINE) begin
      if (last) out_state <= fin_blk;
      else begin
        state_reg <= mix_blk;
        key_reg <= nk;
        rcon <= xt(rcon);
        round <= round + 4'd1;
      end
`ifdef AES_ZEROIZE_EN
    end else if (st == DONE && out_ready) begin
      state_reg <= '0;
      key_reg <= '0;
      out_state <= '0;
`endif
    end
endmodule

// File: tb/tb_aes128_round_engine.sv
// tb_aes128_round_engine: directed FIPS-197 vectors, handshake, backpressure and reset scenarios
module tb_aes128_round_engine;
  logic clk = 0, rst, in_valid, out_ready, in_ready, out_valid, busy;
  logic [127:0] in_state, in_key, out_state;
  int passed = 0, total = 0, cyc = 0;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_round_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic encrypt(input logic [127:0] key, input logic [127:0] pt, output int lat, output logic [127:0] ct);
    in_key = key;
    in_state = pt;
    in_valid = 1;
    tick;
    in_valid = 0;
    in_key = '1;
    in_state = {4{32'hdeadbeef}};
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick;
      lat++;
    end
    ct = out_state;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 1; in_key = K1; in_state = P1; out_ready = 0;
    tick; tick;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passed++;
    total++; if (out_state !== 128'h0) $display("FAIL rst_out_state: got %h exp 0", out_state); else passed++;
    rst = 0; in_valid = 0;
    tick;
    total++; if (busy !== 1'b0) $display("FAIL rst_wins_busy: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_fips_c1;
    int lat;
    logic [127:0] ct, zexp;
`ifdef AES_ZEROIZE_EN
    zexp = '0;
`else
    zexp = C1;
`endif
    encrypt(K1, P1, lat, ct);
    total++; if (lat !== 20) $display("FAIL c1_latency: got %0d exp 20", lat); else passed++;
    total++; if (ct !== C1) $display("FAIL c1_ct: got %h exp %h", ct, C1); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL c1_in_ready_done: got %b exp 0", in_ready); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL c1_busy_done: got %b exp 1", busy); else passed++;
    out_ready = 1;
    tick;
    out_ready = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL c1_valid_drop: got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL c1_in_ready_after: got %b exp 1", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL c1_busy_after: got %b exp 0", busy); else passed++;
    total++; if (out_state !== zexp) $display("FAIL c1_out_after_hs: got %h exp %h", out_state, zexp); else passed++;
  endtask

  task automatic test_fips_b;
    int lat;
    logic [127:0] ct;
    out_ready = 1;
    encrypt(K2, P2, lat, ct);
    total++; if (lat !== 20) $display("FAIL b_latency: got %0d exp 20", lat); else passed++;
    total++; if (ct !== C2) $display("FAIL b_ct: got %h exp %h", ct, C2); else passed++;
    tick;
    out_ready = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL b_valid_drop: got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL b_in_ready_after: got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [127:0] ct;
    encrypt(K1, P1, lat, ct);
    total++; if (ct !== C1) $display("FAIL bp_ct: got %h exp %h", ct, C1); else passed++;
    for (int i = 0; i < 15; i++) begin
      in_valid = i[0];
      in_key = K2;
      in_state = P2;
      tick;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b exp 1", i, out_valid); else passed++;
      total++; if (out_state !== C1) $display("FAIL bp_stable_%0d: got %h exp %h", i, out_state, C1); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b exp 0", i, in_ready); else passed++;
    end
    in_valid = 0;
    out_ready = 1;
    tick;
    out_ready = 0;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after: got %b exp 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_valid_after: got %b exp 0", out_valid); else passed++;
    tick;
    total++; if (busy !== 1'b0) $display("FAIL bp_no_queue: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_back_to_back;
    int n, t1, t2, l1, l2;
    logic [127:0] ct1, ct2;
    out_ready = 1;
    in_key = K1; in_state = P1; in_valid = 1;
    tick;
    t1 = cyc;
    in_key = K2; in_state = P2;
    l1 = 0;
    while (!out_valid && l1 < 100) begin tick; l1++; end
    ct1 = out_state;
    n = 0;
    while (!in_ready && n < 100) begin tick; n++; end
    tick;
    t2 = cyc;
    in_valid = 0;
    l2 = 0;
    while (!out_valid && l2 < 100) begin tick; l2++; end
    ct2 = out_state;
    tick;
    out_ready = 0;
    total++; if (ct1 !== C1) $display("FAIL b2b_ct1: got %h exp %h", ct1, C1); else passed++;
    total++; if (ct2 !== C2) $display("FAIL b2b_ct2: got %h exp %h", ct2, C2); else passed++;
    total++; if (l1 !== 20) $display("FAIL b2b_lat1: got %0d exp 20", l1); else passed++;
    total++; if (l2 !== 20) $display("FAIL b2b_lat2: got %0d exp 20", l2); else passed++;
    total++; if (t2 - t1 < 21) $display("FAIL b2b_spacing: got %0d exp >=21", t2 - t1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle_end: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_mid_reset;
    int lat;
    logic [127:0] ct;
    in_key = K1; in_state = P1; in_valid = 1;
    tick;
    in_valid = 0;
    repeat (8) tick;
    total++; if (busy !== 1'b1) $display("FAIL mr_busy_round5: got %b exp 1", busy); else passed++;
    rst = 1;
    tick;
    rst = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL mr_out_valid: got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL mr_in_ready: got %b exp 1", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mr_busy: got %b exp 0", busy); else passed++;
    total++; if (out_state !== 128'h0) $display("FAIL mr_out_state: got %h exp 0", out_state); else passed++;
    encrypt(K1, P1, lat, ct);
    total++; if (lat !== 20) $display("FAIL mr_latency: got %0d exp 20", lat); else passed++;
    total++; if (ct !== C1) $display("FAIL mr_ct: got %h exp %h", ct, C1); else passed++;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; in_key = '0; in_state = '0;
    test_reset;
    test_fips_c1;
    test_fips_b;
    test_backpressure;
    test_back_to_back;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/aes128_round_engine.md
Name: aes128_round_engine

Overview:
Iterative AES-128 encryption core. It sits directly downstream of the registered T-table lookup stage (table_lookup, S4) and consumes the table outputs.
- Instantiates four table_lookup blocks, one per state column, plus one S4 for on-the-fly key expansion.
- Sequences 10 rounds around those lookups behind a valid/ready block interface.
- Feeds the storage datapath's encryption wrapper with one 128-bit ciphertext block per request.

Parameters:
None (AES-128 only; round count fixed at 10).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext/key request valid
in_ready  output  1  engine can accept a request
in_state  input  128  plaintext; [127:96] = column 0, [127:120] = first byte
in_key  input  128  cipher key, same byte ordering
out_valid  output  1  ciphertext valid
out_ready  input  1  consumer accepts ciphertext
out_state  output  128  ciphertext
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock, named clk. Reset is synchronous and active-high, named rst. Reset is sampled only on the rising edge.
- Reset values: in_ready=1, out_valid=0, out_state=0, busy=0, FSM=IDLE, round=0, rcon=8'h01.
- FSM states: IDLE, LOOKUP, COMBINE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= in_state^in_key; key_reg <= in_key; round <= 1; rcon <= 8'h01; go to LOOKUP.
- LOOKUP:
  - The four state words drive the table_lookup inputs.
  - RotWord(key_reg[31:0]) = {w3[23:0],w3[31:24]} drives S4.
  - Lookups are registered, so results are valid in the next cycle. Go to COMBINE.
- COMBINE, next round key:
  - nk0 = k0^S4out^{rcon,24'h0}; nk1 = k1^nk0; nk2 = k2^nk1; nk3 = k3^nk2.
- COMBINE, rounds 1-9:
  - Column j = p0[j]^p1[j+1]^p2[j+2]^p3[j+3]^nk_j, indices mod 4.
  - key_reg <= nk; rcon <= xtime(rcon), where 8'h80 -> 8'h1b; round++; go to LOOKUP.
- COMBINE, round 10 (no MixColumns):
  - Column j = {p0[j][23:16], p1[j+1][15:8], p2[j+2][7:0], p3[j+3][31:24]} ^ nk_j.
  - Result goes to out_state; out_valid <= 1; go to DONE.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Latency:
  - out_valid rises exactly 20 rising edges after the accepting edge (10 rounds × 2 cycles).
  - Throughput: 1 block per ≥21 cycles.
- DONE:
  - out_valid=1; out_state stable until out_ready.
  - On out_valid&&out_ready: out_valid <= 0; go to IDLE. in_ready is high the following cycle.
- in_ready=0 in LOOKUP, COMBINE and DONE. in_valid in those states is ignored; no queuing, no corruption of the in-flight block.
- in_state/in_key are sampled only on the accepting edge. Later changes have no effect.
- out_ready held high before DONE is harmless. The handshake completes on the first DONE cycle.
- rst asserted mid-operation (any state) aborts the block and restores all reset values next edge. No partial output.
- rst together with in_valid: reset wins; the request is not accepted.
- table_lookup/S4 en inputs are tied to 1'b1.

Optional Feature:
AES_ZEROIZE_EN
- Defined: on the out handshake edge, state_reg, key_reg and out_state are cleared to 0. The cleared value is visible the cycle after the handshake. A mid-operation reset also clears key_reg.
- Not defined: state_reg/key_reg hold their last values and out_state holds the last ciphertext until the next round-10 COMBINE or reset.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_state 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 20 edges after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready=0 for 15 cycles after out_valid -> out_valid and out_state stable; in_valid pulses ignored (in_ready=0); after out_ready=1, in_ready=1 next cycle.
- Back-to-back: C.1 then App. B with in_valid held high and out_ready=1 -> both ciphertexts correct, in order, second accept ≥21 cycles after first.
- Mid-op reset: rst high at round 5 -> next cycle out_valid=0, in_ready=1, busy=0; a subsequent C.1 request yields the correct ciphertext.
- AES_ZEROIZE_EN defined: after the C.1 handshake, out_state reads 0 the next cycle. Not defined: it still reads 69c4e0d8….
